bram_ofmap_reader: RTL and testbench



---
 rtl/bram_ofmap_reader_if.sv | 23 ++
 rtl/bram_ofmap_reader.sv | 170 +++++++++++++++++
 tb/tb_bram_ofmap_reader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_ofmap_reader_if.sv
// Element stream from the ofmap reader toward the next consumer.
// Parameters mirror the reader so the index width is derived identically.
//   oValid : element valid          oReady : consumer accepts element
//   oData  : element value          oIdx   : flat raster index
//   oLast  : element is the final one of the array
// master = reader side, slave = consumer side.
interface bram_ofmap_reader_if #(
  parameter int unsigned K  = 3,
  parameter int unsigned oH = 32,
  parameter int unsigned BW = 16
);
  localparam int unsigned TOTAL = K * oH * oH;
  localparam int unsigned IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic          oValid;
  logic          oReady;
  logic [BW-1:0] oData;
  logic [IW-1:0] oIdx;
  logic          oLast;

  modport master (output oValid, output oData, output oIdx, output oLast, input oReady);
  modport slave  (input oValid, input oData, input oIdx, input oLast, output oReady);
endinterface

// File: rtl/bram_ofmap_reader.sv
// Drains a K x oH x oH ofmap array as a serial element stream in
// channel/row/column raster order, one element per accepted handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a drain (sampled only when idle)
//   abort      : cancel an active drain
//   iData      : ofmap storage contents, read live while streaming
//   s          : element stream (master side of bram_ofmap_reader_if)
//   busy       : high while streaming
//   done       : one-cycle pulse after the last element is accepted
// Optional build macro OFMAP_READER_RELU_EN: negative elements (sign bit set,
// including -0) are replaced by zero as they are loaded onto oData.
module bram_ofmap_reader #(
  parameter int unsigned K  = 3,
  parameter int unsigned oH = 32,
  parameter int unsigned BW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BW-1:0]        iData [K][oH][oH],
  bram_ofmap_reader_if.master  s,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned TOTAL = K * oH * oH;
  localparam int unsigned IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned CW    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW    = (oH > 1) ? $clog2(oH) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] ch_q, ch_d, ch_n;
  logic [PW-1:0] row_q, row_d, row_n;
  logic [PW-1:0] col_q, col_d, col_n;
  logic [BW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          col_wrap, row_wrap;
  logic [IW-1:0] idx_n;

  // Load-path transform applied to every element placed on oData.
  function automatic logic [BW-1:0] load_elem(input logic [BW-1:0] x);
`ifdef OFMAP_READER_RELU_EN
    return x[BW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Raster successor of the current position; column fastest, then row, then channel.
  always_comb begin
    col_wrap = (col_q == PW'(oH - 1));
    row_wrap = (row_q == PW'(oH - 1));
    col_n    = col_wrap ? '0 : col_q + PW'(1);
    row_n    = row_q;
    ch_n     = ch_q;
    if (col_wrap) begin
      row_n = row_wrap ? '0 : row_q + PW'(1);
      if (row_wrap) begin
        ch_n = (ch_q == CW'(K - 1)) ? '0 : ch_q + CW'(1);
      end
    end
    idx_n = idx_q + IW'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          idx_d   = '0;
          ch_d    = '0;
          row_d   = '0;
          col_d   = '0;
          data_d  = load_elem(iData[0][0][0]);
          valid_d = 1'b1;
          last_d  = (TOTAL == 1);
        end
      end
      STREAM: begin
        // abort wins over a handshake landing on the same edge
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          data_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (valid_q && s.oReady) begin
          if (last_q) begin
            state_d = DONE;
            data_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_n;
            ch_d   = ch_n;
            row_d  = row_n;
            col_d  = col_n;
            data_d = load_elem(iData[ch_n][row_n][col_n]);
            last_d = (idx_n == IW'(TOTAL - 1));
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        ch_d    = '0;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == STREAM);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s.oValid = valid_q;
  assign s.oData  = data_q;
  assign s.oIdx   = idx_q;
  assign s.oLast  = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bram_ofmap_reader.sv
// Directed bench for bram_ofmap_reader with a 2 x 2 x 2 ofmap.
module tb_bram_ofmap_reader;

  localparam int unsigned K  = 2;
  localparam int unsigned OH = 2;
  localparam int unsigned BW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [BW-1:0] iData [K][OH][OH];
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  bit relu_phase = 1'b0;

  bram_ofmap_reader_if #(.K(K), .oH(OH), .BW(BW)) bus ();

  bram_ofmap_reader #(.K(K), .oH(OH), .BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .iData (iData),
    .s     (bus.master),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Expected element at raster index i: 3F80 + i, except the two patched
  // slots in the ReLU phase.
  function automatic logic [15:0] exp_data(input int i);
    logic [15:0] v;
    v = 16'h3F80 + 16'(i);
    if (relu_phase && (i == 1 || i == 7)) begin
      v = (i == 1) ? 16'hBF80 : 16'h8000;
`ifdef OFMAP_READER_RELU_EN
      v = 16'h0000;
`endif
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_elem(input int i);
    chk($sformatf("valid[%0d]", i), 32'(bus.oValid), 32'd1);
    chk($sformatf("data[%0d]", i),  32'(bus.oData),  32'(exp_data(i)));
    chk($sformatf("idx[%0d]", i),   32'(bus.oIdx),   32'(i));
    chk($sformatf("last[%0d]", i),  32'(bus.oLast),  (i == 7) ? 32'd1 : 32'd0);
    chk($sformatf("busy[%0d]", i),  32'(busy),       32'd1);
    chk($sformatf("done_low[%0d]", i), 32'(done),    32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_done_then_idle(input string tag);
    chk({tag, "_done"},  32'(done),       32'd1);
    chk({tag, "_valid"}, 32'(bus.oValid), 32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_data"},  32'(bus.oData),  32'd0);
    tick();
    chk({tag, "_done_clr"}, 32'(done),     32'd0);
    chk({tag, "_idx_clr"},  32'(bus.oIdx), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_i;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.oReady = 1'b1;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 2; r++)
        for (int co = 0; co < 2; co++)
          iData[c][r][co] = 16'h3F80 + 16'(4 * c + 2 * r + co);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_valid", 32'(bus.oValid), 32'd0);
    chk("rst_data",  32'(bus.oData),  32'd0);
    chk("rst_idx",   32'(bus.oIdx),   32'd0);
    chk("rst_last",  32'(bus.oLast),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(done),       32'd0);

    // Full-throughput drain
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      check_elem(i);
      tick();
    end
    check_done_then_idle("full");

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    pulse_start();
    exp_i = 0;
    for (int c = 0; c < 40 && exp_i < 8; c++) begin
      bus.oReady = (c % 3 == 0);
      check_elem(exp_i);
      tick();
      if (bus.oReady) exp_i++;
    end
    bus.oReady = 1'b1;
    chk("bp_count", 32'(exp_i), 32'd8);
    check_done_then_idle("bp");

    // start during STREAM is ignored
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      check_elem(i);
      if (i == 3) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check_done_then_idle("restart_ign");

    // New stream from IDLE, aborted while element 5 is being handshaken
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check_elem(i);
      tick();
    end
    check_elem(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(bus.oValid), 32'd0);
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_done",  32'(done),       32'd0);
    chk("abort_last",  32'(bus.oLast),  32'd0);
    tick();
    chk("abort_done2", 32'(done),       32'd0);
    chk("abort_idle",  32'(busy),       32'd0);

    // Restart after abort, then asynchronous reset mid-drain
    pulse_start();
    check_elem(0);
    tick();
    tick();
    check_elem(2);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", 32'(bus.oValid), 32'd0);
    chk("arst_data",  32'(bus.oData),  32'd0);
    chk("arst_idx",   32'(bus.oIdx),   32'd0);
    chk("arst_last",  32'(bus.oLast),  32'd0);
    chk("arst_busy",  32'(busy),       32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_done[%0d]", i),  32'(done),       32'd0);
      chk($sformatf("post_rst_valid[%0d]", i), 32'(bus.oValid), 32'd0);
      chk($sformatf("post_rst_busy[%0d]", i),  32'(busy),       32'd0);
    end

    // Negative and -0 elements: zeroed with ReLU build, passed through otherwise
    iData[0][0][1] = 16'hBF80;
    iData[1][1][1] = 16'h8000;
    relu_phase = 1'b1;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      check_elem(i);
      tick();
    end
    check_done_then_idle("relu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
